// File: rtl/poly_tone_generator.sv
// poly_tone_generator: NUM_CH independent square-wave tone channels with
// shadowed period updates, clean stop on disable, PWM volume gating and a
// first-order sigma-delta mixer that drives a single-pin speaker.
module poly_tone_generator #(
   parameter  int NUM_CH       = 4,
   parameter  int PERIOD_WIDTH = 24,
   parameter  int VOL_WIDTH    = 3,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       output_enable,
   input  logic [VOL_WIDTH-1:0]    volume,
   input  logic                    cfg_valid,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   output logic                    cfg_ready,
   output logic [NUM_CH-1:0]       square_wave_out,
   output logic                    mixed_out,
   output logic [NUM_CH-1:0]       active
);

   // Full-scale mixer input; the accumulator must hold sums up to 2*FS.
   localparam int FS    = NUM_CH * ((1 << VOL_WIDTH) - 1);
   localparam int ACC_W = $clog2(2 * FS + 1);
   localparam int LVL_W = $clog2(NUM_CH + 1);

   localparam logic [CH_W:0]  CH_LIMIT = (CH_W + 1)'(NUM_CH);
   localparam logic [ACC_W-1:0] FS_V  = ACC_W'(FS);

   // Number of channels currently contributing a high level to the mix.
   function automatic logic [LVL_W-1:0] popcount(input logic [NUM_CH-1:0] v);
      logic [LVL_W-1:0] c;
      c = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = c + LVL_W'(v[k]);
      end
      return c;
   endfunction

   logic                    cfg_hit_s;
   logic                    cfg_ready_s;
   logic                    cfg_accept_s;
   logic [NUM_CH-1:0]       pending_s;
   logic [NUM_CH-1:0]       square_s;
   logic [NUM_CH-1:0]       active_s;

   logic [VOL_WIDTH-1:0]    pwm_cnt_r;
   logic                    gate_s;
   logic [NUM_CH-1:0]       swo_r;

   logic [LVL_W-1:0]        level_s;
   logic [ACC_W-1:0]        sum_s;
   logic [ACC_W-1:0]        acc_next_s;
   logic                    mix_next_s;
   logic [ACC_W-1:0]        acc_r;
   logic                    mixed_r;

   // Config handshake: a channel with a queued update refuses further writes;
   // writes to channels that do not exist are swallowed.
   always_comb begin
      cfg_hit_s   = 1'b0;
      cfg_ready_s = 1'b1;
      if ({1'b0, cfg_ch} < CH_LIMIT) begin
         cfg_hit_s   = 1'b1;
         cfg_ready_s = ~pending_s[cfg_ch];
      end else begin
         cfg_hit_s   = 1'b0;
         cfg_ready_s = 1'b1;
      end
   end

   assign cfg_accept_s = cfg_valid & cfg_ready_s & cfg_hit_s;
   assign cfg_ready    = cfg_ready_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [PERIOD_WIDTH-1:0] period_r;
      logic [PERIOD_WIDTH-1:0] shadow_r;
      logic [PERIOD_WIDTH-1:0] cnt_r;
      logic                    pending_r;
      logic                    square_r;
      logic                    active_r;
      logic                    wr_s;
      logic                    boundary_s;
      logic [PERIOD_WIDTH-1:0] next_period_s;

      // Decode this channel's write strobe, half-period boundary and reload value.
      always_comb begin
         wr_s          = cfg_accept_s && (cfg_ch == CH_W'(i));
         boundary_s    = (cnt_r <= PERIOD_WIDTH'(1));
         next_period_s = period_r;
         if (pending_r) begin
            next_period_s = shadow_r;
         end else begin
            next_period_s = period_r;
         end
      end

      // Channel state machine: idle/start, half-period countdown, boundary
      // reload or clean stop, and shadow capture of config writes.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            period_r  <= '0;
            shadow_r  <= '0;
            cnt_r     <= '0;
            pending_r <= 1'b0;
            square_r  <= 1'b0;
            active_r  <= 1'b0;
         end else if (!active_r) begin
            // A stop can leave an update queued; fold it in while idle so the
            // channel never stays locked against new writes.
            if (pending_r) begin
               period_r  <= shadow_r;
               pending_r <= 1'b0;
            end else if (output_enable[i] && (period_r != '0)) begin
               cnt_r    <= period_r;
               square_r <= 1'b0;
               active_r <= 1'b1;
            end
            if (wr_s) begin
               period_r <= cfg_period;
            end
         end else begin
            if (boundary_s) begin
               if (!output_enable[i]) begin
                  square_r <= 1'b0;
                  active_r <= 1'b0;
               end else if (next_period_s == '0) begin
                  period_r  <= next_period_s;
                  pending_r <= 1'b0;
                  square_r  <= 1'b0;
                  active_r  <= 1'b0;
               end else begin
                  period_r  <= next_period_s;
                  pending_r <= 1'b0;
                  cnt_r     <= next_period_s;
                  square_r  <= ~square_r;
               end
            end else begin
               cnt_r <= cnt_r - PERIOD_WIDTH'(1);
            end
            // A write landing on the boundary edge is queued for the next one.
            if (wr_s) begin
               shadow_r  <= cfg_period;
               pending_r <= 1'b1;
            end
         end
      end

      assign pending_s[i] = pending_r;
      assign square_s[i]  = square_r;
      assign active_s[i]  = active_r;
   end

   assign gate_s = (pwm_cnt_r < volume);

   // Free-running PWM phase and volume-gated per-channel outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_r <= '0;
         swo_r     <= '0;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + VOL_WIDTH'(1);
         swo_r     <= square_s & {NUM_CH{gate_s}};
      end
   end

   // Sigma-delta step: add the weighted level, emit a one on each full-scale crossing.
   always_comb begin
      level_s    = popcount(square_s & active_s);
      sum_s      = acc_r + (ACC_W'(level_s) * ACC_W'(volume));
      acc_next_s = sum_s;
      mix_next_s = 1'b0;
      if (sum_s >= FS_V) begin
         acc_next_s = sum_s - FS_V;
         mix_next_s = 1'b1;
      end else begin
         acc_next_s = sum_s;
         mix_next_s = 1'b0;
      end
   end

   // Mixer accumulator and registered 1-bit output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= '0;
         mixed_r <= 1'b0;
      end else begin
         acc_r   <= acc_next_s;
         mixed_r <= mix_next_s;
      end
   end

   assign square_wave_out = swo_r;
   assign mixed_out       = mixed_r;
   assign active          = active_s;

endmodule

// File: tb/tb_poly_tone_generator.sv
// Directed testbench for poly_tone_generator: reset, basic tone, shadowed
// period update, clean stop, full-scale mix and sigma-delta density.
module tb_poly_tone_generator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  output_enable;
   logic [2:0]  volume;
   logic        cfg_valid;
   logic [1:0]  cfg_ch;
   logic [23:0] cfg_period;
   logic        cfg_ready;
   logic [3:0]  square_wave_out;
   logic        mixed_out;
   logic [3:0]  active;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        sq_model = 1'b0;
   logic [3:0]  chmask   = 4'b0001;
   logic        chk_mix  = 1'b0;
   int          ones     = 0;

   poly_tone_generator #(
      .NUM_CH(4),
      .PERIOD_WIDTH(24),
      .VOL_WIDTH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .output_enable(output_enable),
      .volume(volume),
      .cfg_valid(cfg_valid),
      .cfg_ch(cfg_ch),
      .cfg_period(cfg_period),
      .cfg_ready(cfg_ready),
      .square_wave_out(square_wave_out),
      .mixed_out(mixed_out),
      .active(active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock edge. sq_next/act_next are the expected tone level and active
   // flag after this edge; square_wave_out reflects the level before it, gated
   // by the PWM phase of the previous cycle.
   task automatic tick_expect(input logic sq_next, input logic act_next);
      logic gate;
      logic sq_prev;
      gate    = ((cyc % 8) < int'(volume));
      sq_prev = sq_model;
      @(posedge clk);
      #1;
      cyc++;
      check("square_wave_out", 32'(square_wave_out), (sq_prev & gate) ? 32'(chmask) : 32'd0);
      check("active", 32'(active), act_next ? 32'(chmask) : 32'd0);
      if (chk_mix) begin
         check("mixed_out", 32'(mixed_out), 32'(sq_prev));
      end
      sq_model = sq_next;
   endtask

   task automatic half(input int n, input logic lvl);
      for (int i = 0; i < n; i++) begin
         tick_expect(lvl, 1'b1);
      end
   endtask

   initial begin
      output_enable = 4'b0000;
      volume        = 3'd7;
      cfg_valid     = 1'b0;
      cfg_ch        = 2'd0;
      cfg_period    = 24'd0;

      // Power-on reset
      #2 rst = 1'b1;
      #21;
      check("reset_swo", 32'(square_wave_out), 32'd0);
      check("reset_mixed", 32'(mixed_out), 32'd0);
      check("reset_active", 32'(active), 32'd0);
      check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;

      // Basic tone: ch0 P=5, volume 7
      cfg_valid  = 1'b1;
      cfg_ch     = 2'd0;
      cfg_period = 24'd5;
      check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      tick_expect(1'b0, 1'b0);
      cfg_valid     = 1'b0;
      output_enable = 4'b0001;
      half(5, 1'b0);
      half(5, 1'b1);
      half(5, 1'b0);
      half(5, 1'b1);
      half(3, 1'b0);

      // Glitch-free update to P=3 mid low half; second write while pending is refused
      cfg_valid  = 1'b1;
      cfg_period = 24'd3;
      check("cfg_ready_before_wr", 32'(cfg_ready), 32'd1);
      tick_expect(1'b0, 1'b1);
      cfg_period = 24'd7;
      check("cfg_ready_pending1", 32'(cfg_ready), 32'd0);
      tick_expect(1'b0, 1'b1);
      check("cfg_ready_pending2", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      tick_expect(1'b1, 1'b1);
      check("cfg_ready_applied", 32'(cfg_ready), 32'd1);
      half(2, 1'b1);
      half(3, 1'b0);
      half(1, 1'b1);

      // Back to P=5 via another shadowed write
      cfg_valid  = 1'b1;
      cfg_period = 24'd5;
      tick_expect(1'b1, 1'b1);
      cfg_valid = 1'b0;
      tick_expect(1'b1, 1'b1);

      // Enable glitch low then high inside a half: no effect
      half(2, 1'b0);
      output_enable = 4'b0000;
      half(1, 1'b0);
      output_enable = 4'b0001;
      half(2, 1'b0);

      // Clean stop: disable 2 cycles into the high half
      half(2, 1'b1);
      output_enable = 4'b0000;
      half(3, 1'b1);
      tick_expect(1'b0, 1'b0);
      tick_expect(1'b0, 1'b0);

      // Restart, then write P=0 to stop at the next boundary
      output_enable = 4'b0001;
      tick_expect(1'b0, 1'b1);
      tick_expect(1'b0, 1'b1);
      cfg_valid  = 1'b1;
      cfg_period = 24'd0;
      check("cfg_ready_p0", 32'(cfg_ready), 32'd1);
      tick_expect(1'b0, 1'b1);
      cfg_valid = 1'b0;
      check("cfg_ready_p0_pending", 32'(cfg_ready), 32'd0);
      tick_expect(1'b0, 1'b1);
      tick_expect(1'b0, 1'b1);
      tick_expect(1'b0, 1'b0);
      check("cfg_ready_p0_done", 32'(cfg_ready), 32'd1);
      tick_expect(1'b0, 1'b0);

      // Restart at P=5 and assert reset mid high half
      cfg_valid  = 1'b1;
      cfg_period = 24'd5;
      tick_expect(1'b0, 1'b0);
      cfg_valid = 1'b0;
      half(5, 1'b0);
      half(2, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst_swo", 32'(square_wave_out), 32'd0);
      check("midrst_mixed", 32'(mixed_out), 32'd0);
      check("midrst_active", 32'(active), 32'd0);
      check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
      output_enable = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      cyc      = 0;
      sq_model = 1'b0;
      tick_expect(1'b0, 1'b0);
      tick_expect(1'b0, 1'b0);
      tick_expect(1'b0, 1'b0);

      // Mixer full scale: all channels P=4, enabled together, volume 7
      for (int c = 0; c < 4; c++) begin
         cfg_valid  = 1'b1;
         cfg_ch     = 2'(c);
         cfg_period = 24'd4;
         check("cfg_ready_fs", 32'(cfg_ready), 32'd1);
         tick_expect(1'b0, 1'b0);
      end
      cfg_valid     = 1'b0;
      cfg_ch        = 2'd0;
      output_enable = 4'b1111;
      chmask        = 4'b1111;
      chk_mix       = 1'b1;
      half(4, 1'b0);
      half(4, 1'b1);
      half(4, 1'b0);
      half(4, 1'b1);
      output_enable = 4'b0000;
      tick_expect(1'b0, 1'b0);
      chk_mix = 1'b0;

      // Mixer density: ch0 only, P=200, volume 3 -> 3 ones per 28 cycles
      cfg_valid  = 1'b1;
      cfg_period = 24'd200;
      volume     = 3'd3;
      chmask     = 4'b0001;
      tick_expect(1'b0, 1'b0);
      cfg_valid     = 1'b0;
      output_enable = 4'b0001;
      half(200, 1'b0);
      ones = 0;
      for (int i = 0; i < 200; i++) begin
         tick_expect(1'b1, 1'b1);
         if (i >= 29 && i < 141) begin
            ones += int'(mixed_out);
            if (((i - 29) % 28) == 27) begin
               check("mix_density", 32'(ones), 32'd3);
               ones = 0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_tone_generator.md
# poly_tone_generator

Multi-channel square-wave tone source for the audio path: NUM_CH independent tone channels, each with a programmable half-period. Each channel has a glitch-free period update via a valid/ready config port, a clean stop on disable, and an N-level PWM volume. A sigma-delta mixer combines all channels into one 1-bit output for the single-pin speaker driver. It replaces the single-channel, 1-bit-volume tone generator.

## Interface
- NUM_CH, 4, number of tone channels (≥1)
- PERIOD_WIDTH, 24, half-period width in clk cycles
- VOL_WIDTH, 3, volume width; duty levels 0..2^VOL_WIDTH-1
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- output_enable  in  NUM_CH  per-channel enable
- volume  in  VOL_WIDTH  global volume; 0 = silent
- cfg_valid  in  1  period write request
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_period  in  PERIOD_WIDTH  new half-period; 0 = silence channel
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- square_wave_out  out  NUM_CH  per-channel tone, PWM-gated by volume
- mixed_out  out  1  sigma-delta mix of all channels
- active  out  NUM_CH  channel currently generating

## Operation
- Per-channel state: period (PERIOD_WIDTH), shadow, pending, down-counter, square bit, active. All reset to 0.
- Idle channel: active=0, square=0. Start condition is output_enable[i]=1 and period≠0. Next edge: counter←period, square←0, active←1.
- Running channel: the counter decrements each cycle. Boundary = counter==1 (counter≤1 treated as boundary). At the boundary:
  - If enable=1: square toggles; period←shadow if pending, else unchanged; pending←0; counter←new period.
  - If enable=0: square←0, active←0 (clean stop; the current half-period is never truncated).
  - If the new period is 0: square←0, active←0.
- Half-period = P cycles, full tone period = 2P cycles. P=1 toggles every cycle.
- Config port: cfg_ready = !pending[cfg_ch] (combinational).
  - Accepted write to an idle channel: period←cfg_period directly, pending stays 0.
  - Accepted write to an active channel: shadow←cfg_period, pending←1. Takes effect at the next boundary.
  - Write accepted in the same cycle as that channel's boundary: the boundary reloads the old period, pending is set, and the new value applies at the following boundary.
  - cfg_ch ≥ NUM_CH: cfg_ready=1, write dropped.
- PWM: free-running pwm_cnt (VOL_WIDTH bits, wraps). gate = (pwm_cnt < volume). square_wave_out[i] ← square[i] & gate (registered).
- Mixer:
  - level = popcount(square & active), range 0..NUM_CH.
  - FS = NUM_CH·(2^VOL_WIDTH−1).
  - sum = acc + level·volume. If sum ≥ FS: mixed_out←1, acc←sum−FS; else mixed_out←0, acc←sum.
  - acc width must hold 2·FS without overflow.
  - One-count density = level·volume/FS.

## Timing
- Reset values: square_wave_out=0, mixed_out=0, active=0, pwm_cnt=0, acc=0, all periods/shadows/pending=0. cfg_ready=1 during and after reset.
- Reset asserted mid-operation clears all outputs immediately (asynchronous), independent of clk.
- Enable to first square rise: 1 cycle to load, then P cycles. square_wave_out lags the internal square by 1 cycle.
- mixed_out lags the internal square by 1 cycle.
- cfg_ready for an active channel stays low from the edge after acceptance until the edge of the applying boundary.
- Enable toggled low then high within one half-period: no effect; the channel keeps running.
- volume changes take effect on the next cycle, with no phase reset of any counter.

## Test plan
- Reset: assert rst asynchronously mid-run with ch0 at P=5 → all outputs 0 before the next clk edge. cfg_ready=1. After release, active=0 until re-enabled.
- Basic tone: write ch0 P=5, enable ch0, volume=7 → square toggles every 5 cycles (10-cycle period). square_wave_out[0] high on 7 of every 8 cycles while square is high.
- Glitch-free update: ch0 running P=5, write P=3 two cycles after a boundary → current half lasts 5 cycles, then halves of 3. cfg_ready (cfg_ch=0) is low until that boundary. A second write during pending is not accepted.
- Clean stop: deassert enable 2 cycles into a high half with P=5 → square stays high 3 more cycles, then 0. active falls at the same edge. Write P=0 to a running channel → stops at the next boundary.
- Mixer full scale: all 4 channels P=4, enabled the same cycle, volume=7 → mixed_out constant 1 during high halves and 0 during low halves.
- Mixer density: only ch0 running with P=200 at volume=3 → during a high half, exactly 3 ones in every 28 consecutive cycles after the first 28.
